spad_fill_ctrl: RTL and testbench

Drains 16-bit words from the PE input FIFO (read side of `fifo_wrapper`) and writes them into a PE scratchpad (ifmap or filter spad) starting at a given base address with circular wrap-around. It sits directly downstream of the FIFO and upstream of the spad write port. It issues FIFO reads, tracks the one-cycle FIFO read latency, and reports `busy`/`done` to the PE control FSM.

---
 rtl/spad_fill_ctrl_pkg.sv | 15 +
 rtl/spad_addr_gen.sv | 27 ++
 rtl/spad_fill_ctrl.sv | 125 ++++++++++++
 tb/tb_spad_fill_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spad_fill_ctrl_pkg.sv
// Shared constants and state encoding for the PE scratchpad fill path.
// The spad, the FIFO wrapper and the fill controller all use these values.
package spad_fill_ctrl_pkg;

  localparam int PE_DATA_WIDTH = 16;
  localparam int PE_SPAD_DEPTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/spad_addr_gen.sv
// Loadable modulo-SPAD_DEPTH write address counter for the scratchpad.
// A load takes priority over an increment in the same cycle.
module spad_addr_gen
  import spad_fill_ctrl_pkg::*;
#(
  parameter int SPAD_DEPTH = PE_SPAD_DEPTH,
  parameter int ADDR_WIDTH = $clog2(SPAD_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (inc) begin
      addr <= (addr == ADDR_WIDTH'(SPAD_DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/spad_fill_ctrl.sv
// Drains words from the PE input FIFO into a scratchpad with circular
// addressing, tracking the one-cycle FIFO read latency.
module spad_fill_ctrl
  import spad_fill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int SPAD_DEPTH = PE_SPAD_DEPTH,
  parameter int ADDR_WIDTH = $clog2(SPAD_DEPTH),
  parameter int CNT_WIDTH  = $clog2(SPAD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  fill_count,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  fifo_empty_flag,
  output logic                  fifo_read_request,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  spad_we,
  output logic [ADDR_WIDTH-1:0] spad_waddr,
  output logic [DATA_WIDTH-1:0] spad_wdata,
  output logic                  busy,
  output logic                  done
);

  fill_state_e           state, state_nxt;
  logic [CNT_WIDTH-1:0]  count_q, issued_q, written_q;
  logic [CNT_WIDTH-1:0]  eff_count;
  logic                  start_acc;
  logic                  final_wr;
  logic                  busy_q;
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] wdata_hold_p1;

  function automatic logic [CNT_WIDTH-1:0] sat_count(input logic [CNT_WIDTH-1:0] c);
    if (c > CNT_WIDTH'(SPAD_DEPTH)) return CNT_WIDTH'(SPAD_DEPTH);
    return c;
  endfunction

  assign eff_count = sat_count(fill_count);
  assign start_acc = (state == ST_IDLE) && start && !abort;

  // Write stage: data returned for a read issued last cycle, dropped on abort
  assign spad_we    = vld_p0 && !abort;
  assign spad_wdata = spad_we ? fifo_rd_data : wdata_hold_p1;
  assign final_wr   = (state == ST_DRAIN) && spad_we &&
                      (written_q == count_q - CNT_WIDTH'(1));
  assign busy       = busy_q;
  assign done       = (state == ST_DONE);

  always_comb begin
    state_nxt         = state;
    fifo_read_request = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_acc) state_nxt = (eff_count == '0) ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        fifo_read_request = !fifo_empty_flag && (issued_q < count_q);
        if (fifo_read_request && (issued_q + CNT_WIDTH'(1) == count_q))
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (final_wr) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt         = ST_IDLE;
      fifo_read_request = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count_q   <= '0;
      issued_q  <= '0;
      written_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        count_q   <= eff_count;
        issued_q  <= '0;
        written_q <= '0;
      end else begin
        if (fifo_read_request) issued_q <= issued_q + CNT_WIDTH'(1);
        if (spad_we) written_q <= written_q + CNT_WIDTH'(1);
      end
      // Count 0 enters DONE with busy set, so DONE itself also clears busy
      if (abort) busy_q <= 1'b0;
      else if (start_acc) busy_q <= 1'b1;
      else if (final_wr || state == ST_DONE) busy_q <= 1'b0;
    end
  end

  // Issue stage: a granted read is in flight for exactly one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0        <= 1'b0;
      wdata_hold_p1 <= '0;
    end else begin
      vld_p0 <= fifo_read_request;
      if (spad_we) wdata_hold_p1 <= fifo_rd_data;
    end
  end

  spad_addr_gen #(
    .SPAD_DEPTH (SPAD_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load  (start_acc),
    .base  (base_addr),
    .inc   (spad_we),
    .addr  (spad_waddr)
  );

endmodule

// File: tb/tb_spad_fill_ctrl.sv
// Directed bench for spad_fill_ctrl with a behavioural one-cycle-latency FIFO.
module tb_spad_fill_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] fill_count = '0;
  logic [AW-1:0] base_addr = '0;
  logic          fifo_empty_flag;
  logic          fifo_read_request;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          spad_we;
  logic [AW-1:0] spad_waddr;
  logic [DW-1:0] spad_wdata;
  logic          busy;
  logic          done;

  spad_fill_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .fill_count        (fill_count),
    .base_addr         (base_addr),
    .fifo_empty_flag   (fifo_empty_flag),
    .fifo_read_request (fifo_read_request),
    .fifo_rd_data      (fifo_rd_data),
    .spad_we           (spad_we),
    .spad_waddr        (spad_waddr),
    .spad_wdata        (spad_wdata),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: empty flag and read data both update on the consuming edge
  logic [DW-1:0] fifo_mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          hold_empty = 1'b0;
  logic          fifo_flush = 1'b0;
  assign fifo_empty_flag = (wr_ptr == rd_ptr) || hold_empty;

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_read_request && (wr_ptr != rd_ptr)) begin
      fifo_rd_data <= fifo_mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Observation log, sampled on the falling edge
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            n_req = 0, n_done = 0, done_cyc = -1, viol = 0;
  logic          busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (spad_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(spad_waddr);
      wr_data.push_back(spad_wdata);
    end
    if (fifo_read_request) begin
      n_req++;
      if (fifo_empty_flag) viol++;
    end
    if (done) begin
      n_done++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic flush_fifo;
    fifo_flush = 1'b1;
    tick(1);
    fifo_flush = 1'b0;
  endtask

  task automatic do_start(input int cnt, input int base, output int s);
    start      = 1'b1;
    fill_count = CW'(cnt);
    base_addr  = AW'(base);
    s          = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (spad_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b exp 0", spad_we); end
    checks++; if (spad_waddr !== 4'd0) begin fails++; $display("FAIL reset_waddr: got %0d exp 0", spad_waddr); end
    checks++; if (spad_wdata !== 16'd0) begin fails++; $display("FAIL reset_wdata: got %h exp 0", spad_wdata); end
    checks++; if (fifo_read_request !== 1'b0) begin fails++; $display("FAIL reset_req: got %b exp 0", fifo_read_request); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_basic;
    int s, b0, bd, br;
    logic [DW-1:0] exp_d [4];
    exp_d = '{16'h11, 16'h22, 16'h33, 16'h44};
    for (int i = 0; i < 4; i++) push(exp_d[i]);
    b0 = wr_cyc.size(); bd = n_done; br = n_req;
    do_start(4, 0, s);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b exp 1", busy); end
    checks++; if (fifo_read_request !== 1'b1) begin fails++; $display("FAIL basic_first_req: got %b exp 1", fifo_read_request); end
    checks++; if (spad_we !== 1'b0) begin fails++; $display("FAIL basic_we_s1: got %b exp 0", spad_we); end
    tick(8);
    checks++; if (wr_cyc.size() - b0 !== 4) begin fails++; $display("FAIL basic_nwr: got %0d exp 4", wr_cyc.size() - b0); end
    if (wr_cyc.size() - b0 >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wr_addr[b0+i] !== AW'(i)) begin fails++; $display("FAIL basic_addr%0d: got %0d exp %0d", i, wr_addr[b0+i], i); end
        checks++; if (wr_data[b0+i] !== exp_d[i]) begin fails++; $display("FAIL basic_data%0d: got %h exp %h", i, wr_data[b0+i], exp_d[i]); end
        checks++; if (wr_cyc[b0+i] !== s + 2 + i) begin fails++; $display("FAIL basic_cyc%0d: got %0d exp %0d", i, wr_cyc[b0+i] - s, 2 + i); end
      end
    end
    checks++; if (n_done - bd !== 1) begin fails++; $display("FAIL basic_ndone: got %0d exp 1", n_done - bd); end
    checks++; if (done_cyc - s !== 6) begin fails++; $display("FAIL basic_done_cyc: got S+%0d exp S+6", done_cyc - s); end
    checks++; if (busy_at_done !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b exp 0", busy_at_done); end
    checks++; if (n_req - br !== 4) begin fails++; $display("FAIL basic_nreq: got %0d exp 4", n_req - br); end
  endtask

  task automatic test_wrap;
    int s, b0;
    logic [AW-1:0] exp_a [5];
    exp_a = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd2};
    for (int i = 1; i <= 5; i++) push(DW'(i));
    b0 = wr_cyc.size();
    do_start(5, 10, s);
    tick(9);
    checks++; if (wr_cyc.size() - b0 !== 5) begin fails++; $display("FAIL wrap_nwr: got %0d exp 5", wr_cyc.size() - b0); end
    if (wr_cyc.size() - b0 >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (wr_addr[b0+i] !== exp_a[i]) begin fails++; $display("FAIL wrap_addr%0d: got %0d exp %0d", i, wr_addr[b0+i], exp_a[i]); end
        checks++; if (wr_data[b0+i] !== DW'(i + 1)) begin fails++; $display("FAIL wrap_data%0d: got %h exp %h", i, wr_data[b0+i], i + 1); end
      end
    end
  endtask

  task automatic test_stall;
    int s, b0, bd, br, v0;
    for (int i = 0; i < 6; i++) push(16'h0A00 + DW'(i));
    b0 = wr_cyc.size(); bd = n_done; br = n_req; v0 = viol;
    do_start(6, 0, s);
    tick(2);
    hold_empty = 1'b1;
    #1;
    checks++; if (fifo_read_request !== 1'b0) begin fails++; $display("FAIL stall_req_while_empty: got %b exp 0", fifo_read_request); end
    tick(3);
    hold_empty = 1'b0;
    tick(8);
    checks++; if (n_req - br !== 6) begin fails++; $display("FAIL stall_nreq: got %0d exp 6", n_req - br); end
    checks++; if (viol - v0 !== 0) begin fails++; $display("FAIL stall_req_empty: got %0d exp 0", viol - v0); end
    checks++; if (wr_cyc.size() - b0 !== 6) begin fails++; $display("FAIL stall_nwr: got %0d exp 6", wr_cyc.size() - b0); end
    if (wr_cyc.size() - b0 >= 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (wr_data[b0+i] !== 16'h0A00 + DW'(i)) begin fails++; $display("FAIL stall_data%0d: got %h exp %h", i, wr_data[b0+i], 16'h0A00 + i); end
      end
      checks++; if (wr_cyc[b0+2] - s !== 7) begin fails++; $display("FAIL stall_resume: got S+%0d exp S+7", wr_cyc[b0+2] - s); end
    end
    checks++; if (n_done - bd !== 1) begin fails++; $display("FAIL stall_ndone: got %0d exp 1", n_done - bd); end
    checks++; if (done_cyc - s !== 11) begin fails++; $display("FAIL stall_done_cyc: got S+%0d exp S+11", done_cyc - s); end
  endtask

  task automatic test_zero;
    int s, b0, br;
    push(16'hDEAD);
    b0 = wr_cyc.size(); br = n_req;
    do_start(0, 5, s);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL zero_busy_s1: got %b exp 1", busy); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done_s1: got %b exp 1", done); end
    checks++; if (fifo_read_request !== 1'b0) begin fails++; $display("FAIL zero_req: got %b exp 0", fifo_read_request); end
    tick(1);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_s2: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_s2: got %b exp 0", done); end
    tick(2);
    checks++; if (wr_cyc.size() - b0 !== 0) begin fails++; $display("FAIL zero_nwr: got %0d exp 0", wr_cyc.size() - b0); end
    checks++; if (n_req - br !== 0) begin fails++; $display("FAIL zero_nreq: got %0d exp 0", n_req - br); end
    flush_fifo();
  endtask

  task automatic test_clamp;
    int s, b0, bd;
    for (int i = 0; i < 14; i++) push(16'h0100 + DW'(i));
    b0 = wr_cyc.size(); bd = n_done;
    do_start(15, 3, s);
    tick(16);
    checks++; if (wr_cyc.size() - b0 !== 12) begin fails++; $display("FAIL clamp_nwr: got %0d exp 12", wr_cyc.size() - b0); end
    if (wr_cyc.size() - b0 >= 12) begin
      checks++; if (wr_addr[b0+8] !== 4'd11) begin fails++; $display("FAIL clamp_addr8: got %0d exp 11", wr_addr[b0+8]); end
      checks++; if (wr_addr[b0+11] !== 4'd2) begin fails++; $display("FAIL clamp_addr11: got %0d exp 2", wr_addr[b0+11]); end
      checks++; if (wr_data[b0+11] !== 16'h010B) begin fails++; $display("FAIL clamp_data11: got %h exp 010b", wr_data[b0+11]); end
    end
    checks++; if (n_done - bd !== 1 || done_cyc - s !== 14) begin fails++; $display("FAIL clamp_done: got n=%0d S+%0d exp n=1 S+14", n_done - bd, done_cyc - s); end
    flush_fifo();
  endtask

  task automatic test_abort;
    int s, b0, bd, br;
    for (int i = 0; i < 6; i++) push(16'h0B00 + DW'(i));
    b0 = wr_cyc.size(); bd = n_done; br = n_req;
    do_start(6, 0, s);
    tick(2);
    abort = 1'b1;
    #1;
    checks++; if (fifo_read_request !== 1'b0) begin fails++; $display("FAIL abort_req: got %b exp 0", fifo_read_request); end
    checks++; if (spad_we !== 1'b0) begin fails++; $display("FAIL abort_we: got %b exp 0", spad_we); end
    tick(1);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b exp 0", busy); end
    tick(6);
    checks++; if (wr_cyc.size() - b0 !== 1) begin fails++; $display("FAIL abort_nwr: got %0d exp 1", wr_cyc.size() - b0); end
    checks++; if (n_req - br !== 2) begin fails++; $display("FAIL abort_nreq: got %0d exp 2", n_req - br); end
    checks++; if (n_done - bd !== 0) begin fails++; $display("FAIL abort_done: got %0d exp 0", n_done - bd); end
    flush_fifo();
  endtask

  task automatic test_back_to_back;
    int s, s2, b0, bd;
    for (int i = 0; i < 4; i++) push(16'h0C00 + DW'(i));
    b0 = wr_cyc.size(); bd = n_done;
    do_start(4, 0, s);
    tick(1);
    do_start(2, 5, s2);
    tick(6);
    checks++; if (wr_cyc.size() - b0 !== 4) begin fails++; $display("FAIL b2b_nwr: got %0d exp 4", wr_cyc.size() - b0); end
    if (wr_cyc.size() - b0 >= 4) begin
      checks++; if (wr_addr[b0+3] !== 4'd3) begin fails++; $display("FAIL b2b_addr3: got %0d exp 3", wr_addr[b0+3]); end
    end
    checks++; if (n_done - bd !== 1 || done_cyc - s !== 6) begin fails++; $display("FAIL b2b_done: got n=%0d S+%0d exp n=1 S+6", n_done - bd, done_cyc - s); end
    push(16'h0D01);
    b0 = wr_cyc.size();
    do_start(1, 9, s);
    tick(4);
    checks++; if (wr_cyc.size() - b0 !== 1 || wr_addr[b0] !== 4'd9 || wr_data[b0] !== 16'h0D01) begin
      fails++; $display("FAIL b2b_restart: got n=%0d addr=%0d data=%h exp n=1 addr=9 data=0d01", wr_cyc.size() - b0, wr_addr[b0], wr_data[b0]);
    end
  endtask

  task automatic test_async_reset;
    int s, b0, bd;
    for (int i = 0; i < 6; i++) push(16'h0E00 + DW'(i));
    do_start(6, 7, s);
    tick(2);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy: got %b exp 0", busy); end
    checks++; if (spad_we !== 1'b0) begin fails++; $display("FAIL areset_we: got %b exp 0", spad_we); end
    checks++; if (spad_waddr !== 4'd0) begin fails++; $display("FAIL areset_waddr: got %0d exp 0", spad_waddr); end
    checks++; if (spad_wdata !== 16'd0) begin fails++; $display("FAIL areset_wdata: got %h exp 0", spad_wdata); end
    checks++; if (fifo_read_request !== 1'b0) begin fails++; $display("FAIL areset_req: got %b exp 0", fifo_read_request); end
    tick(2);
    reset = 1'b1;
    flush_fifo();
    push(16'h00A1);
    push(16'h00A2);
    b0 = wr_cyc.size(); bd = n_done;
    do_start(2, 4, s);
    tick(6);
    checks++; if (wr_cyc.size() - b0 !== 2) begin fails++; $display("FAIL areset_nwr: got %0d exp 2", wr_cyc.size() - b0); end
    if (wr_cyc.size() - b0 >= 2) begin
      checks++; if (wr_addr[b0+1] !== 4'd5 || wr_data[b0+1] !== 16'h00A2) begin
        fails++; $display("FAIL areset_w1: got addr=%0d data=%h exp addr=5 data=00a2", wr_addr[b0+1], wr_data[b0+1]);
      end
    end
    checks++; if (n_done - bd !== 1 || done_cyc - s !== 4) begin fails++; $display("FAIL areset_done: got n=%0d S+%0d exp n=1 S+4", n_done - bd, done_cyc - s); end
    checks++; if (viol !== 0) begin fails++; $display("FAIL req_while_empty_total: got %0d exp 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
